// File: rtl/seven_seg_scanner.sv
// Four-digit multiplexed seven-segment scanner with per-digit blank, blink and dp.
// Inputs are snapshotted once per frame; outputs are registered.
module seven_seg_scanner #(
   parameter int REFRESH_DIV = 100000,
   parameter int GUARD       = 1000,
   parameter int BLINK_DIV   = 25000000
) (
   input  logic        clk_100mhz,
   input  logic        rst,
   input  logic [15:0] digits,
   input  logic [3:0]  dp_en,
   input  logic [3:0]  blank,
   input  logic [3:0]  blink_en,
   output logic [3:0]  an,
   output logic [6:0]  seg,
   output logic        dp
);

   localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
   localparam int BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    idx_q, idx_d;
   logic [BW-1:0] bcnt_q, bcnt_d;
   logic          phase_q, phase_d;

   logic [15:0]   sh_dig_q, sh_dig_d;
   logic [3:0]    sh_dp_q, sh_dp_d;
   logic [3:0]    sh_blank_q, sh_blank_d;
   logic [3:0]    sh_blink_q, sh_blink_d;

   logic [3:0]    an_q, an_d;
   logic [6:0]    seg_q, seg_d;
   logic          dp_q, dp_d;

   logic          cnt_wrap;
   logic          frame_end;
   logic          dark;
   logic [3:0]    nib;

   function automatic logic [6:0] hex7(input logic [3:0] h);
      logic [6:0] s;
      unique case (h)
         4'h0: s = 7'b1000000;
         4'h1: s = 7'b1111001;
         4'h2: s = 7'b0100100;
         4'h3: s = 7'b0110000;
         4'h4: s = 7'b0011001;
         4'h5: s = 7'b0010010;
         4'h6: s = 7'b0000010;
         4'h7: s = 7'b1111000;
         4'h8: s = 7'b0000000;
         4'h9: s = 7'b0010000;
         4'hA: s = 7'b0001000;
         4'hB: s = 7'b0000011;
         4'hC: s = 7'b1000110;
         4'hD: s = 7'b0100001;
         4'hE: s = 7'b0000110;
         default: s = 7'b0001110;
      endcase
      return s;
   endfunction

   assign cnt_wrap  = (cnt_q == CW'(REFRESH_DIV - 1));
   assign frame_end = cnt_wrap && (idx_q == 2'd3);
   assign nib       = sh_dig_q[{idx_q, 2'b00} +: 4];
   assign dark      = sh_blank_q[idx_q] | (sh_blink_q[idx_q] & ~phase_q);

   always_comb begin
      cnt_d      = cnt_wrap ? '0 : cnt_q + 1'b1;
      idx_d      = cnt_wrap ? idx_q + 2'd1 : idx_q;
      bcnt_d     = bcnt_q + 1'b1;
      phase_d    = phase_q;
      sh_dig_d   = sh_dig_q;
      sh_dp_d    = sh_dp_q;
      sh_blank_d = sh_blank_q;
      sh_blink_d = sh_blink_q;
      if (bcnt_q == BW'(BLINK_DIV - 1)) begin
         bcnt_d  = '0;
         phase_d = ~phase_q;
      end
      // Snapshot only at frame boundary so a frame never mixes old/new data
      if (frame_end) begin
         sh_dig_d   = digits;
         sh_dp_d    = dp_en;
         sh_blank_d = blank;
         sh_blink_d = blink_en;
      end
   end

   always_comb begin
      an_d  = 4'b1111;
      seg_d = 7'h7F;
      dp_d  = 1'b1;
      if (!(cnt_q < CW'(GUARD)) && !dark) begin
         an_d  = ~(4'b0001 << idx_q);
         seg_d = hex7(nib);
         dp_d  = ~sh_dp_q[idx_q];
      end
   end

   always_ff @(posedge clk_100mhz or posedge rst) begin
      if (rst) begin
         cnt_q      <= '0;
         idx_q      <= '0;
         bcnt_q     <= '0;
         phase_q    <= 1'b1;
         sh_dig_q   <= '0;
         sh_dp_q    <= '0;
         sh_blank_q <= 4'b1111;
         sh_blink_q <= '0;
         an_q       <= 4'b1111;
         seg_q      <= 7'h7F;
         dp_q       <= 1'b1;
      end else begin
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         bcnt_q     <= bcnt_d;
         phase_q    <= phase_d;
         sh_dig_q   <= sh_dig_d;
         sh_dp_q    <= sh_dp_d;
         sh_blank_q <= sh_blank_d;
         sh_blink_q <= sh_blink_d;
         an_q       <= an_d;
         seg_q      <= seg_d;
         dp_q       <= dp_d;
      end
   end

   assign an  = an_q;
   assign seg = seg_q;
   assign dp  = dp_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Scoreboard bench for seven_seg_scanner: a cycle model queues expected
// outputs at each rising edge; they are compared on the falling edge.
module tb_seven_seg_scanner;

   localparam int R = 8;
   localparam int G = 2;
   localparam int B = 64;

   logic        clk;
   logic        rst;
   logic [15:0] digits;
   logic [3:0]  dp_en;
   logic [3:0]  blank;
   logic [3:0]  blink_en;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp;

   int errors = 0;
   int checks = 0;

   seven_seg_scanner #(
      .REFRESH_DIV(R),
      .GUARD(G),
      .BLINK_DIV(B)
   ) dut (
      .clk_100mhz(clk),
      .rst(rst),
      .digits(digits),
      .dp_en(dp_en),
      .blank(blank),
      .blink_en(blink_en),
      .an(an),
      .seg(seg),
      .dp(dp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   localparam logic [6:0] DEC [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
   };
   localparam logic [11:0] OFF = {4'b1111, 7'h7F, 1'b1};

   // reference model state
   int          m_cnt;
   int          m_idx;
   int          m_bcnt;
   bit          m_ph;
   logic [15:0] m_dig;
   logic [3:0]  m_dp;
   logic [3:0]  m_blank;
   logic [3:0]  m_blink;
   logic [11:0] q[$];

   always @(posedge clk or posedge rst) begin
      logic [11:0] e;
      logic [3:0]  n;
      if (rst) begin
         m_cnt = 0; m_idx = 0; m_bcnt = 0; m_ph = 1'b1;
         m_dig = '0; m_dp = '0; m_blank = 4'b1111; m_blink = '0;
         q.delete();
      end else begin
         e = OFF;
         n = m_dig[m_idx*4 +: 4];
         if (m_cnt >= G && !m_blank[m_idx] && !(m_blink[m_idx] && !m_ph)) begin
            e[11:8] = 4'b1111;
            e[8 + m_idx] = 1'b0;
            e[7:1] = DEC[n];
            e[0] = ~m_dp[m_idx];
         end
         q.push_back(e);
         if (m_idx == 3 && m_cnt == R - 1) begin
            m_dig = digits; m_dp = dp_en;
            m_blank = blank; m_blink = blink_en;
         end
         if (m_cnt == R - 1) begin
            m_cnt = 0;
            m_idx = (m_idx + 1) % 4;
         end else begin
            m_cnt++;
         end
         if (m_bcnt == B - 1) begin
            m_bcnt = 0;
            m_ph = ~m_ph;
         end else begin
            m_bcnt++;
         end
      end
   end

   // scoreboard compare plus anode-safety checker
   logic [3:0] prev_an = 4'b1111;
   int         off_run = 0;
   always @(negedge clk) begin
      logic [11:0] e;
      e = (rst || q.size() == 0) ? OFF : q.pop_front();
      checks++;
      assert ({an, seg, dp} === e) else begin
         errors++;
         $error("FAIL out: an/seg/dp got %b/%b/%b exp %b/%b/%b",
                an, seg, dp, e[11:8], e[7:1], e[0]);
      end
      checks++;
      assert ($countones(~an) <= 1) else begin
         errors++;
         $error("FAIL onehot: an=%b", an);
      end
      if (an != 4'b1111 && an != prev_an) begin
         checks++;
         assert (prev_an == 4'b1111 && off_run >= G) else begin
            errors++;
            $error("FAIL guard: an %b->%b off_run=%0d need %0d",
                   prev_an, an, off_run, G);
         end
      end
      off_run = (an == 4'b1111) ? off_run + 1 : 0;
      prev_an = an;
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_idx(input int want);
      int k;
      k = 0;
      while (!(m_idx == want && m_cnt == 3) && k < 200) begin
         @(negedge clk);
         k++;
      end
      checks++;
      assert (k < 200) else begin
         errors++;
         $error("FAIL wait_idx: timeout got %0d exp %0d", m_idx, want);
      end
   endtask

   initial begin
      int dp_lo;
      int dp_bad;
      int lit;
      rst = 1'b1;
      digits = 16'h1234;
      dp_en = '0;
      blank = '0;
      blink_en = '0;
      step(3);
      checks++;
      assert (an === 4'b1111 && seg === 7'h7F && dp === 1'b1) else begin
         errors++;
         $error("FAIL reset: got %b/%h/%b exp 1111/7f/1", an, seg, dp);
      end
      #1 rst = 1'b0;

      // dark for one full frame after reset release
      lit = 0;
      repeat (33) begin
         @(negedge clk);
         if (an != 4'b1111) lit++;
      end
      checks++;
      assert (lit == 0) else begin
         errors++;
         $error("FAIL dark_start: lit cycles %0d exp 0", lit);
      end
      step(100);

      // mid-frame change is held off until the next snapshot
      wait_idx(1);
      #1 digits = 16'hABCD;
      step(80);

      // blink digit 0
      #1 blink_en = 4'b0001;
      step(300);

      // dp on digit 2, digit 3 blanked
      #1 begin
         blink_en = '0;
         dp_en = 4'b0100;
         blank = 4'b1000;
      end
      step(40);
      dp_lo = 0;
      dp_bad = 0;
      repeat (64) begin
         @(negedge clk);
         if (dp == 1'b0) begin
            dp_lo++;
            if (an != 4'b1011) dp_bad++;
         end
         if (an == 4'b0111) dp_bad++;
      end
      checks++;
      assert (dp_lo > 0 && dp_bad == 0) else begin
         errors++;
         $error("FAIL dp_slot: dp_lo=%0d bad=%0d exp >0/0", dp_lo, dp_bad);
      end

      // async reset in the middle of slot 2
      wait_idx(2);
      #2 rst = 1'b1;
      #1;
      checks++;
      assert (an === 4'b1111 && seg === 7'h7F && dp === 1'b1) else begin
         errors++;
         $error("FAIL async_rst: got %b/%h/%b exp 1111/7f/1", an, seg, dp);
      end
      step(3);
      #1 rst = 1'b0;
      lit = 0;
      repeat (33) begin
         @(negedge clk);
         if (an != 4'b1111) lit++;
      end
      checks++;
      assert (lit == 0) else begin
         errors++;
         $error("FAIL dark_rerst: lit cycles %0d exp 0", lit);
      end
      step(70);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
